// File: rtl/game_pkg.sv
// game_pkg: status encodings, key codes, screen geometry and the motion state type
// shared by the per-frame game blocks.
package game_pkg;

   localparam logic [4:0] ST_SELECT = 5'b10000;
   localparam logic [4:0] ST_WAIT   = 5'b01000;
   localparam logic [4:0] ST_PLAY   = 5'b00100;
   localparam logic [4:0] ST_WIN    = 5'b00010;
   localparam logic [4:0] ST_LOSE   = 5'b00001;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam int STICKMAN_H    = 50;
   localparam int SCREEN_BOTTOM = 479;

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      RISING   = 2'd1,
      FALLING  = 2'd2,
      FROZEN   = 2'd3
   } motion_state_t;

endpackage

// File: rtl/frame_tick_det.sv
// frame_tick_det: registers the slow frame_clk level into the Clk domain and emits
// a one-Clk tick on its rising edge.
module frame_tick_det (
   input  logic Clk,
   input  logic Reset_n,
   input  logic frame_clk,
   output logic tick
);

   logic frame_clk_r;
   logic frame_clk_d;

   // NOTE: sequential state uses non-blocking assignments so both flops sample the
   // pre-edge values and form a true two-stage pipeline.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         frame_clk_r <= 1'b0;
         frame_clk_d <= 1'b0;
      end else begin
         frame_clk_r <= frame_clk;
         frame_clk_d <= frame_clk_r;
      end
   end

   assign tick = frame_clk_r & ~frame_clk_d;

endmodule

// File: rtl/stickman_motion.sv
// stickman_motion: per-frame jump/gravity integrator for the stickman's top Y.
// Defining STICKMAN_DOUBLE_JUMP_EN allows one extra jump while airborne.
module stickman_motion
   import game_pkg::*;
#(
   parameter logic [9:0] START_TOP  = 10'd380,
   parameter int         JUMP_V     = 12,
   parameter int         GRAVITY    = 1,
   parameter int         MAX_FALL_V = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [4:0] status,
   input  logic [9:0] GroundY,
   output logic [9:0] StickmanTop,
   output logic [1:0] motion_state
);

   localparam logic signed [11:0] H_S          = 12'(STICKMAN_H);
   localparam logic signed [11:0] BOTTOM_TOP_S = 12'(SCREEN_BOTTOM - STICKMAN_H);
   localparam logic signed [11:0] GRAV_S       = 12'(GRAVITY);
   localparam logic signed [11:0] MAX_FALL_S   = 12'(MAX_FALL_V);
   localparam logic signed [6:0]  JUMP_VY      = 7'(-JUMP_V);

   motion_state_t     state_q, state_d;
   logic [9:0]        top_q, top_d;
   logic signed [6:0] vy_q, vy_d;
   logic [7:0]        key_d;
   logic              jump_req_q, req_clr, press, tick, air_jump;
   logic              is_idle, is_over, is_play;

   logic signed [11:0] top_s, vy_s, feet_s, ground_s;
   logic signed [11:0] rise_top, rise_vy, fall_vy_raw, fall_vy, next_feet;
   logic signed [11:0] fall_top_raw, fall_top;

   frame_tick_det u_tick (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .frame_clk (frame_clk),
      .tick      (tick)
   );

   assign press   = (keycode == KEY_W) && (key_d != KEY_W);
   assign is_idle = (status == ST_WAIT) || (status == ST_SELECT);
   assign is_over = (status == ST_WIN) || (status == ST_LOSE);
   assign is_play = (status == ST_PLAY);

   assign top_s        = {2'b00, top_q};
   assign vy_s         = {{5{vy_q[6]}}, vy_q};
   assign ground_s     = {2'b00, GroundY};
   assign feet_s       = top_s + H_S;
   assign rise_top     = top_s + vy_s;
   assign rise_vy      = vy_s + GRAV_S;
   assign fall_vy_raw  = vy_s + GRAV_S;
   assign fall_vy      = (fall_vy_raw > MAX_FALL_S) ? MAX_FALL_S : fall_vy_raw;
   assign next_feet    = feet_s + fall_vy;
   assign fall_top_raw = top_s + fall_vy;
   assign fall_top     = (fall_top_raw > BOTTOM_TOP_S) ? BOTTOM_TOP_S : fall_top_raw;

   // NOTE: every output of this block gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      top_d   = top_q;
      vy_d    = vy_q;
      req_clr = 1'b0;
      if (is_idle) begin
         state_d = GROUNDED;
         top_d   = START_TOP;
         vy_d    = '0;
         req_clr = 1'b1;
      end else if (is_over) begin
         state_d = FROZEN;
         req_clr = 1'b1;
      end else if (!is_play) begin
         req_clr = 1'b1;
      end else begin
         case (state_q)
            FROZEN: begin
               state_d = GROUNDED;
               top_d   = START_TOP;
               vy_d    = '0;
            end
            GROUNDED: begin
               if (jump_req_q) begin
                  vy_d    = JUMP_VY;
                  state_d = RISING;
                  req_clr = 1'b1;
               end else if (feet_s < ground_s) begin
                  vy_d    = '0;
                  state_d = FALLING;
               end
            end
            default: begin
               // Airborne: a pending request either becomes the air jump or is dropped.
               req_clr = 1'b1;
               if (air_jump) begin
                  vy_d    = JUMP_VY;
                  state_d = RISING;
               end else if (state_q == RISING) begin
                  if (rise_top < 0) begin
                     top_d   = '0;
                     vy_d    = '0;
                     state_d = FALLING;
                  end else begin
                     top_d = rise_top[9:0];
                     vy_d  = rise_vy[6:0];
                     if (!rise_vy[11]) state_d = FALLING;
                  end
               end else if (feet_s <= ground_s && next_feet >= ground_s) begin
                  top_d   = 10'(ground_s - H_S);
                  vy_d    = '0;
                  state_d = GROUNDED;
               end else begin
                  top_d = fall_top[9:0];
                  vy_d  = fall_vy[6:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q    <= GROUNDED;
         top_q      <= START_TOP;
         vy_q       <= '0;
         jump_req_q <= 1'b0;
         key_d      <= '0;
      end else begin
         key_d      <= keycode;
         jump_req_q <= (jump_req_q & ~(tick & req_clr)) | press;
         if (tick) begin
            state_q <= state_d;
            top_q   <= top_d;
            vy_q    <= vy_d;
         end
      end
   end

`ifdef STICKMAN_DOUBLE_JUMP_EN
   logic air_jump_used_q;

   assign air_jump = jump_req_q & ~air_jump_used_q;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         air_jump_used_q <= 1'b0;
      end else if (tick) begin
         if (state_d == GROUNDED)
            air_jump_used_q <= 1'b0;
         else if (is_play && air_jump && (state_q == RISING || state_q == FALLING))
            air_jump_used_q <= 1'b1;
      end
   end
`else
   assign air_jump = 1'b0;
`endif

   assign StickmanTop  = top_q;
   assign motion_state = state_q;

endmodule

// File: tb/tb_stickman_motion.sv
// tb_stickman_motion: directed and random frames checked against an integer reference
// model of the stickman's jump/fall rules.
module tb_stickman_motion;
   import game_pkg::*;

`ifdef STICKMAN_DOUBLE_JUMP_EN
   localparam bit DJ_EN = 1'b1;
`else
   localparam bit DJ_EN = 1'b0;
`endif

   logic       Clk       = 1'b0;
   logic       Reset_n   = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode   = 8'h00;
   logic [4:0] status    = ST_PLAY;
   logic [9:0] GroundY   = 10'd430;
   logic [9:0] StickmanTop;
   logic [1:0] motion_state;

   stickman_motion dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .frame_clk    (frame_clk),
      .keycode      (keycode),
      .status       (status),
      .GroundY      (GroundY),
      .StickmanTop  (StickmanTop),
      .motion_state (motion_state)
   );

   always #10 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // reference model: 0=grounded 1=rising 2=falling 3=frozen
   int         m_top  = 380;
   int         m_vy   = 0;
   int         m_st   = 0;
   bit         m_req  = 1'b0;
   bit         m_used = 1'b0;
   logic [7:0] m_key  = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_top = 380; m_vy = 0; m_st = 0; m_req = 1'b0; m_used = 1'b0; m_key = 8'h00;
   endtask

   task automatic model_step();
      bit fire;
      int gy;
      fire = 1'b0;
      gy   = int'(GroundY);
      if (status == ST_WAIT || status == ST_SELECT) begin
         m_top = 380; m_vy = 0; m_st = 0; m_req = 1'b0;
      end else if (status == ST_WIN || status == ST_LOSE) begin
         m_st = 3; m_req = 1'b0;
      end else if (status != ST_PLAY) begin
         m_req = 1'b0;
      end else if (m_st == 3) begin
         m_st = 0; m_top = 380; m_vy = 0;
      end else if (m_st == 0) begin
         if (m_req) begin
            m_vy = -12; m_st = 1; m_req = 1'b0;
         end else if (m_top + 50 < gy) begin
            m_vy = 0; m_st = 2;
         end
      end else begin
         fire  = DJ_EN && m_req && !m_used;
         m_req = 1'b0;
         if (fire) begin
            m_vy = -12; m_st = 1; m_used = 1'b1;
         end else if (m_st == 1) begin
            if (m_top + m_vy < 0) begin
               m_top = 0; m_vy = 0; m_st = 2;
            end else begin
               m_top = m_top + m_vy;
               m_vy  = m_vy + 1;
               if (m_vy >= 0) m_st = 2;
            end
         end else begin
            m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
            if (m_top + 50 <= gy && m_top + 50 + m_vy >= gy) begin
               m_top = gy - 50; m_vy = 0; m_st = 0;
            end else begin
               m_top = m_top + m_vy;
               if (m_top > 429) m_top = 429;
            end
         end
      end
      if (m_st == 0) m_used = 1'b0;
   endtask

   // One frame: key applied with frame_clk rising, outputs checked after the tick edge.
   task automatic frame(input logic [7:0] key, input string tag);
      @(negedge Clk);
      keycode   = key;
      frame_clk = 1'b1;
      if (key == KEY_W && m_key != KEY_W) m_req = 1'b1;
      m_key = key;
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
      model_step();
      check({tag, ".top"}, 32'(StickmanTop), 32'(m_top));
      check({tag, ".state"}, 32'(motion_state), 32'(m_st));
   endtask

   initial begin
      int jumps;
      int held;
      logic [1:0] prev;
      logic [7:0] k;
      int r;

      // reset with status already playing
      repeat (2) @(negedge Clk);
      check("reset.top", 32'(StickmanTop), 32'd380);
      check("reset.state", 32'(motion_state), 32'd0);
      Reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) frame(8'h00, "idle");
      check("idle.top_const", 32'(StickmanTop), 32'd380);

      // full jump: 1 + 12 rising + 14 falling ticks
      frame(KEY_W, "jump.start");
      check("jump.start_rising", 32'(motion_state), 32'd1);
      check("jump.start_top", 32'(StickmanTop), 32'd380);
      for (int i = 0; i < 12; i++) frame(KEY_W, "jump.rise");
      check("jump.apex_top", 32'(StickmanTop), 32'd302);
      check("jump.apex_falling", 32'(motion_state), 32'd2);
      for (int i = 0; i < 14; i++) frame(KEY_W, "jump.fall");
      check("jump.land_top", 32'(StickmanTop), 32'd380);
      check("jump.land_grounded", 32'(motion_state), 32'd0);
      frame(8'h00, "jump.release");

      // holding W yields a single jump
      jumps = 0;
      prev  = motion_state;
      for (int i = 0; i < 60; i++) begin
         frame(KEY_W, "hold");
         if (motion_state == 2'd1 && prev == 2'd0) jumps++;
         prev = motion_state;
      end
      check("hold.one_jump", 32'(jumps), 32'd1);
      frame(8'h00, "hold.release");
      frame(KEY_W, "hold.repress");
      check("hold.repress_rising", 32'(motion_state), 32'd1);
      for (int i = 0; i < 30; i++) frame(8'h00, "hold.settle");

      // pit: ground drops from 430 to 479
      GroundY = 10'd479;
      frame(8'h00, "pit.start");
      check("pit.falling", 32'(motion_state), 32'd2);
      for (int i = 0; i < 9; i++) frame(8'h00, "pit.fall");
      check("pit.feet_9th", 32'(StickmanTop + 10'd50 >= 10'd470), 32'd1);
      frame(8'h00, "pit.land");
      check("pit.land_top", 32'(StickmanTop), 32'd429);
      check("pit.land_grounded", 32'(motion_state), 32'd0);

      // lose mid-rise freezes, waiting restores start position
      status  = ST_WAIT;
      GroundY = 10'd430;
      frame(8'h00, "wait");
      status = ST_PLAY;
      frame(KEY_W, "lose.jump");
      for (int i = 0; i < 3; i++) frame(8'h00, "lose.rise");
      held   = m_top;
      status = ST_LOSE;
      frame(8'h00, "lose.freeze");
      check("lose.frozen", 32'(motion_state), 32'd3);
      check("lose.top_held", 32'(StickmanTop), 32'(held));
      frame(KEY_W, "lose.hold");
      status = ST_WAIT;
      frame(8'h00, "lose.wait");
      check("lose.wait_top", 32'(StickmanTop), 32'd380);
      check("lose.wait_grounded", 32'(motion_state), 32'd0);

      // reset asserted mid-jump
      status = ST_PLAY;
      frame(KEY_W, "rst.jump");
      for (int i = 0; i < 4; i++) frame(8'h00, "rst.rise");
      @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      check("rst.top", 32'(StickmanTop), 32'd380);
      check("rst.state", 32'(motion_state), 32'd0);
      Reset_n = 1'b1;
      model_reset();

      // press while falling: air jump if enabled, ignored otherwise
      frame(8'h00, "air.pre");
      frame(KEY_W, "air.jump");
      for (int i = 0; i < 14; i++) frame(8'h00, "air.rise");
      frame(KEY_W, "air.press2");
      check("air.press2_state", 32'(motion_state), DJ_EN ? 32'd1 : 32'd2);
      frame(8'h00, "air.rel");
      frame(KEY_W, "air.press3");
      for (int i = 0; i < 60; i++) frame(8'h00, "air.settle");
      check("air.landed", 32'(motion_state), 32'd0);

      // randomized frames
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 2))
            0:       k = KEY_W;
            1:       k = KEY_SPACE;
            default: k = 8'h00;
         endcase
         r = int'($urandom_range(0, 19));
         case (r)
            0:       status = ST_WIN;
            1:       status = ST_LOSE;
            2:       status = ST_WAIT;
            3:       status = ST_SELECT;
            default: status = ST_PLAY;
         endcase
         if ($urandom_range(0, 9) == 0) GroundY = 10'($urandom_range(400, 479));
         frame(k, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
